frame_scheduler: RTL and testbench
==================================

FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 Parameter WIDTH, default 28, frame payload width fed to frame_assembly.
REQ-002 Parameter SYNC_PERIOD, default 16, non-sync frames between consecutive sync frames.
REQ-003 Parameter IDLE_GAP, default 8, empty cycles before an idle frame is inserted.
REQ-004 Parameters SYNC_WORD 28'hA5A5A5A, IDLE_WORD 28'h0000000: fixed payloads.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 en  in  1  scheduler enable.
REQ-008 a_data  in  WIDTH; a_valid  in  1; a_ready  out  1: primary data requester.
REQ-009 b_data  in  WIDTH; b_valid  in  1; b_ready  out  1: secondary (telemetry) requester.
REQ-010 fa_din  out  WIDTH; fa_vin  out  1; fa_type  out  2: frame to assembler (0=A, 1=B, 2=SYNC, 3=IDLE).
REQ-011 fa_ready  in  1  assembler accepts the frame when fa_vin and fa_ready are both high.

Function
REQ-012 fa_din/fa_type/fa_vin SHALL be registered and held stable while fa_vin=1 and fa_ready=0.
REQ-013 A new frame SHALL load when fa_vin=0 or fa_ready=1 (load_ok); sustained throughput one frame/cycle.
REQ-014 a_ready/b_ready SHALL be combinational: high only in the cycle that source's word loads (grant & load_ok & state RUN).
REQ-015 FSM states OFF, SYNC, RUN; OFF->SYNC when en=1; SYNC->RUN when the sync frame loads; RUN->SYNC when sync due; any->OFF when en=0.
REQ-016 Load priority in RUN: sync due > round-robin A/B > idle.
REQ-017 Round-robin pointer SHALL flip to the other source only after a data grant; single requester always granted.
REQ-018 Frame counter SHALL count loaded A/B/IDLE frames; at SYNC_PERIOD it SHALL clear and set sync due.
REQ-019 Idle counter SHALL increment each RUN cycle with no valid request and fa_vin=0; at IDLE_GAP load IDLE_WORD and clear; any load clears it.
REQ-020 Counter widths SHALL be $clog2(max+1); no wrap beyond terminal value.
REQ-021 In OFF no loads occur and both readys stay low; a held frame SHALL remain until accepted.
REQ-022 First frame after reset or en rising SHALL be a SYNC frame.
REQ-023 en falling and load_ok in same cycle: no load; en rising: SYNC frame loads next load_ok cycle.

Reset
REQ-024 On rst=0: state OFF, fa_vin=0, fa_din=0, fa_type=0, a_ready=b_ready=0, pointer=A, counters=0.
REQ-025 Reset mid-transfer SHALL drop the held frame immediately; no source word lost since readys are combinational.

Structure
REQ-026 frame_type_t enum (A, B, SYNC, IDLE), state enum, SYNC_WORD/IDLE_WORD SHALL live in shared package frame_pkg.
REQ-027 Round-robin grant logic SHALL be one sub-module rr_arbiter2 (2 requests, pointer, grant one-hot).

Verification
REQ-028 Reset release, en=1, fa_ready=1, no requests -> SYNC frame (type 2, 28'hA5A5A5A) first, IDLE frame after 8 empty cycles.
REQ-029 a_valid and b_valid held high, fa_ready=1 -> types alternate A,B,A,B...; SYNC inserted after exactly 16 data frames.
REQ-030 fa_ready low 5 cycles with fa_vin=1 -> fa_din/fa_type unchanged, a_ready=b_ready=0 throughout.
REQ-031 Only a_valid=1, a_data=28'h0000001 -> every data frame type 0 with matching payload; b_ready never high.
REQ-032 en dropped mid-stream -> no new loads, held frame accepted, readys low; en re-raised -> next frame SYNC.
REQ-033 rst asserted while fa_vin=1 -> fa_vin=0 same cycle; after release SYNC frame precedes any data.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared types and fixed payloads for the frame scheduler.
package frame_pkg;

  typedef enum logic [1:0] {
    FT_A    = 2'd0,
    FT_B    = 2'd1,
    FT_SYNC = 2'd2,
    FT_IDLE = 2'd3
  } frame_type_t;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } sched_state_t;

  localparam logic [27:0] FRAME_SYNC_WORD = 28'hA5A5A5A;
  localparam logic [27:0] FRAME_IDLE_WORD = 28'h0000000;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: ptr=0 favours req[0] on conflict, ptr=1 favours req[1].
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req[0] && (!req[1] || !ptr)) grant = 2'b01;
    else if (req[1])                 grant = 2'b10;
  end

endmodule

// File: rtl/frame_scheduler.sv
// Frame scheduler: interleaves A/B data with periodic SYNC frames and gap-filling IDLE
// frames into a single registered valid/ready stream toward the frame assembler.
module frame_scheduler
  import frame_pkg::*;
#(
  parameter int              WIDTH       = 28,
  parameter int              SYNC_PERIOD = 16,
  parameter int              IDLE_GAP    = 8,
  parameter logic [WIDTH-1:0] SYNC_WORD  = FRAME_SYNC_WORD,
  parameter logic [WIDTH-1:0] IDLE_WORD  = FRAME_IDLE_WORD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] fa_din,
  output logic             fa_vin,
  output logic [1:0]       fa_type,
  input  logic             fa_ready
);

  localparam int FC_W = $clog2(SYNC_PERIOD + 1);
  localparam int IC_W = $clog2(IDLE_GAP + 1);

  sched_state_t    state;
  logic            ptr;
  logic [FC_W-1:0] frame_cnt;
  logic [IC_W-1:0] idle_cnt;
  logic [1:0]      grant;
  logic            load_ok, run_slot, data_go, idle_go, no_req;

  rr_arbiter2 u_arb (
    .req   ({b_valid, a_valid}),
    .ptr   (ptr),
    .grant (grant)
  );

  assign load_ok  = !fa_vin || fa_ready;
  assign run_slot = (state == ST_RUN) && en && load_ok;
  assign no_req   = !a_valid && !b_valid;
  assign data_go  = run_slot && (grant != 2'b00);
  // Idle frame fills the last empty slot of the gap, so the stream shows exactly IDLE_GAP empty cycles.
  assign idle_go  = (state == ST_RUN) && en && no_req && !fa_vin &&
                    (idle_cnt == IC_W'(IDLE_GAP - 1));
  assign a_ready  = run_slot && grant[0];
  assign b_ready  = run_slot && grant[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_OFF;
      fa_vin    <= 1'b0;
      fa_din    <= '0;
      fa_type   <= FT_A;
      ptr       <= 1'b0;
      frame_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      if (fa_ready) fa_vin <= 1'b0;
      case (state)
        ST_OFF: begin
          idle_cnt <= '0;
          if (en) state <= ST_SYNC;
        end
        ST_SYNC: begin
          idle_cnt <= '0;
          if (!en) state <= ST_OFF;
          else if (load_ok) begin
            fa_vin    <= 1'b1;
            fa_din    <= SYNC_WORD;
            fa_type   <= FT_SYNC;
            frame_cnt <= '0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!en) begin
            state    <= ST_OFF;
            idle_cnt <= '0;
          end else if (data_go || idle_go) begin
            fa_vin   <= 1'b1;
            idle_cnt <= '0;
            if (data_go) begin
              fa_din  <= grant[0] ? a_data : b_data;
              fa_type <= grant[0] ? FT_A : FT_B;
              ptr     <= grant[0];
            end else begin
              fa_din  <= IDLE_WORD;
              fa_type <= FT_IDLE;
            end
            // Hitting the period hands the very next load slot to the sync frame.
            if (frame_cnt == FC_W'(SYNC_PERIOD - 1)) begin
              frame_cnt <= '0;
              state     <= ST_SYNC;
            end else begin
              frame_cnt <= frame_cnt + FC_W'(1);
            end
          end else if (no_req && !fa_vin) begin
            idle_cnt <= idle_cnt + IC_W'(1);
          end
        end
        default: state <= ST_OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler: directed vector table, hand sequences, random run vs. a frame-level model.
module tb_frame_scheduler;

  localparam int          SYNC_PERIOD = 16;
  localparam int          IDLE_GAP    = 8;
  localparam logic [27:0] SYNC_W      = 28'hA5A5A5A;

  logic        clk = 1'b0, rst = 1'b0, en = 1'b0;
  logic [27:0] a_data = '0, b_data = '0, fa_din;
  logic        a_valid = 1'b0, b_valid = 1'b0, a_ready, b_ready, fa_vin, fa_ready = 1'b0;
  logic [1:0]  fa_type;

  int checks = 0, errors = 0;

  frame_scheduler dut (
    .clk(clk), .rst(rst), .en(en),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .fa_din(fa_din), .fa_vin(fa_vin), .fa_type(fa_type), .fa_ready(fa_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit e, input bit av, input logic [27:0] ad,
                       input bit bv, input logic [27:0] bd, input bit fr);
    en = e; a_valid = av; a_data = ad; b_valid = bv; b_data = bd; fa_ready = fr;
  endtask

  task automatic tick(input bit e, input bit av, input logic [27:0] ad,
                      input bit bv, input logic [27:0] bd, input bit fr);
    drive(e, av, ad, bv, bd, fr);
    @(posedge clk); #1;
  endtask

  // ---------------- reference model: frames as seen by the assembler ----------------
  int          m_phase, n_phase;   // 0 disabled, 1 sync owed, 2 streaming
  bit          m_vin, n_vin, m_prefer_b, n_prefer_b;
  logic [27:0] m_din, n_din;
  logic [1:0]  m_type, n_type;
  int          m_since, n_since, m_empty, n_empty;

  task automatic model_init();
    m_phase = 0; m_vin = 0; m_din = '0; m_type = 2'd0;
    m_prefer_b = 0; m_since = 0; m_empty = 0;
  endtask

  task automatic model_step(input bit e, input bit av, input bit bv,
                            input logic [27:0] ad, input logic [27:0] bd, input bit fr,
                            output bit ar, output bit br);
    bit slot, loaded, pick_a;
    slot = !m_vin || fr;
    loaded = 0; ar = 0; br = 0;
    n_phase = m_phase; n_vin = m_vin; n_din = m_din; n_type = m_type;
    n_prefer_b = m_prefer_b; n_since = m_since; n_empty = m_empty;
    if (!e || m_phase != 2) n_empty = 0;
    if (!e) n_phase = 0;
    else if (m_phase == 0) n_phase = 1;
    else if (m_phase == 1) begin
      if (slot) begin
        n_vin = 1; n_din = SYNC_W; n_type = 2'd2; n_since = 0; n_phase = 2; loaded = 1;
      end
    end else begin
      if (slot && (av || bv)) begin
        pick_a = av && !(bv && m_prefer_b);
        ar = pick_a; br = !pick_a;
        n_vin = 1; n_din = pick_a ? ad : bd; n_type = pick_a ? 2'd0 : 2'd1;
        n_prefer_b = pick_a; loaded = 1;
      end else if (!av && !bv && !m_vin) begin
        if (m_empty + 1 >= IDLE_GAP) begin
          n_vin = 1; n_din = '0; n_type = 2'd3; loaded = 1;
        end else n_empty = m_empty + 1;
      end
      if (loaded) begin
        n_empty = 0;
        n_since = m_since + 1;
        if (n_since >= SYNC_PERIOD) begin n_since = 0; n_phase = 1; end
      end
    end
    if (!loaded && fr) n_vin = 0;
  endtask

  task automatic mcycle(input bit e, input bit av, input bit bv,
                        input logic [27:0] ad, input logic [27:0] bd, input bit fr);
    bit ear, ebr;
    drive(e, av, ad, bv, bd, fr);
    #1;
    model_step(e, av, bv, ad, bd, fr, ear, ebr);
    chk("rnd_a_ready", 32'(a_ready), 32'(ear));
    chk("rnd_b_ready", 32'(b_ready), 32'(ebr));
    @(posedge clk); #1;
    m_phase = n_phase; m_vin = n_vin; m_din = n_din; m_type = n_type;
    m_prefer_b = n_prefer_b; m_since = n_since; m_empty = n_empty;
    chk("rnd_fa_vin", 32'(fa_vin), 32'(m_vin));
    chk("rnd_fa_type", 32'(fa_type), 32'(m_type));
    chk("rnd_fa_din", 32'(fa_din), 32'(m_din));
  endtask

  task automatic do_reset();
    drive(0, 0, '0, 0, '0, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fa_vin", 32'(fa_vin), 32'd0);
    chk("rst_fa_din", 32'(fa_din), 32'd0);
    chk("rst_fa_type", 32'(fa_type), 32'd0);
    chk("rst_readys", 32'({a_ready, b_ready}), 32'd0);
    rst = 1'b1;
    model_init();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit en, av, bv, fr;
    bit ar, br, vin;
    logic [1:0]  typ;
    logic [27:0] din;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //            en av bv fr  ar br vin type din
    tbl[0]  = '{1, 0, 0, 1,  0, 0, 0, 2'd0, 28'h0};
    tbl[1]  = '{1, 0, 0, 1,  0, 0, 1, 2'd2, SYNC_W};
    tbl[2]  = '{1, 1, 1, 1,  1, 0, 1, 2'd0, 28'h1};
    tbl[3]  = '{1, 1, 1, 1,  0, 1, 1, 2'd1, 28'h2};
    tbl[4]  = '{1, 1, 1, 0,  0, 0, 1, 2'd1, 28'h2};
    tbl[5]  = '{1, 1, 1, 1,  1, 0, 1, 2'd0, 28'h1};
    tbl[6]  = '{0, 1, 1, 0,  0, 0, 1, 2'd0, 28'h1};
    tbl[7]  = '{0, 1, 1, 1,  0, 0, 0, 2'd0, 28'h1};
    tbl[8]  = '{1, 1, 1, 1,  0, 0, 0, 2'd0, 28'h1};
    tbl[9]  = '{1, 1, 1, 1,  0, 0, 1, 2'd2, SYNC_W};
    tbl[10] = '{1, 1, 1, 1,  0, 1, 1, 2'd1, 28'h2};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].en, tbl[i].av, 28'h1, tbl[i].bv, 28'h2, tbl[i].fr);
      #1;
      chk($sformatf("vec%0d_a_ready", i), 32'(a_ready), 32'(tbl[i].ar));
      chk($sformatf("vec%0d_b_ready", i), 32'(b_ready), 32'(tbl[i].br));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_fa_vin", i), 32'(fa_vin), 32'(tbl[i].vin));
      chk($sformatf("vec%0d_fa_type", i), 32'(fa_type), 32'(tbl[i].typ));
      chk($sformatf("vec%0d_fa_din", i), 32'(fa_din), 32'(tbl[i].din));
    end

    // Sync first, then exactly IDLE_GAP empty cycles, then an idle frame.
    do_reset();
    repeat (2) tick(1, 0, '0, 0, '0, 1);
    chk("gap_sync_type", 32'(fa_type), 32'd2);
    chk("gap_sync_din", 32'(fa_din), 32'(SYNC_W));
    for (int i = 0; i < IDLE_GAP; i++) begin
      tick(1, 0, '0, 0, '0, 1);
      chk($sformatf("gap_empty%0d", i), 32'(fa_vin), 32'd0);
    end
    tick(1, 0, '0, 0, '0, 1);
    chk("gap_idle_vin", 32'(fa_vin), 32'd1);
    chk("gap_idle_type", 32'(fa_type), 32'd3);
    chk("gap_idle_din", 32'(fa_din), 32'd0);

    // Both requesters saturated: A/B alternate, sync after SYNC_PERIOD data frames.
    do_reset();
    repeat (2) tick(1, 1, 28'h111, 1, 28'h222, 1);
    chk("rr_sync_type", 32'(fa_type), 32'd2);
    for (int i = 0; i < SYNC_PERIOD; i++) begin
      tick(1, 1, 28'h111, 1, 28'h222, 1);
      chk($sformatf("rr_type%0d", i), 32'(fa_type), 32'(i % 2));
      chk($sformatf("rr_din%0d", i), 32'(fa_din), (i % 2) ? 32'h222 : 32'h111);
    end
    tick(1, 1, 28'h111, 1, 28'h222, 1);
    chk("rr_resync_type", 32'(fa_type), 32'd2);
    tick(1, 1, 28'h111, 1, 28'h222, 1);
    chk("rr_after_sync_type", 32'(fa_type), 32'd0);

    // Reset while a frame is held drops it at once; sync precedes data afterwards.
    drive(1, 1, 28'h111, 1, 28'h222, 0);
    rst = 1'b0;
    #1;
    chk("midrst_fa_vin", 32'(fa_vin), 32'd0);
    chk("midrst_a_ready", 32'(a_ready), 32'd0);
    #2;
    rst = 1'b1;
    tick(1, 1, 28'h111, 1, 28'h222, 1);
    chk("midrst_wait_vin", 32'(fa_vin), 32'd0);
    tick(1, 1, 28'h111, 1, 28'h222, 1);
    chk("midrst_sync_type", 32'(fa_type), 32'd2);

    // Assembler stalls five cycles: frame frozen, no source granted.
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 28'h111, 1, 28'h222, 0);
      #1;
      chk($sformatf("stall%0d_readys", i), 32'({a_ready, b_ready}), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("stall%0d_type", i), 32'(fa_type), 32'd2);
      chk($sformatf("stall%0d_din", i), 32'(fa_din), 32'(SYNC_W));
      chk($sformatf("stall%0d_vin", i), 32'(fa_vin), 32'd1);
    end

    // Randomized run against the model.
    do_reset();
    for (int i = 0; i < 400; i++)
      mcycle(($urandom % 20) != 0, $urandom % 2, $urandom % 2,
             28'($urandom), 28'($urandom), ($urandom % 10) < 7);
    for (int i = 0; i < 250; i++)
      mcycle(($urandom % 40) != 0, ($urandom % 4) != 0, 1'b0,
             28'h0000001, 28'($urandom), ($urandom % 10) < 8);
    for (int i = 0; i < 300; i++)
      mcycle(($urandom % 60) != 0, ($urandom % 10) == 0, ($urandom % 10) == 0,
             28'($urandom), 28'($urandom), ($urandom % 10) < 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
